// File: rtl/uart_pkg.sv
// Shared UART receive types and constants.
// Frame is 8N1: sample 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
package uart_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } rx_state_t;

    localparam int BAUD_DIV_DEFAULT = 434;

    localparam logic [3:0] START_IDX = 4'd0;
    localparam logic [3:0] STOP_IDX  = 4'd9;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous level; 2-cycle latency, no backpressure.
// Both flops reset to 1 so an idle-high line never looks like a start bit out of reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d};
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling off a baud down-counter; rdy about 2+9.5 bit times after the falling edge.
// No backpressure: a new frame overwrites rx_data; rdy is held until clr_rdy or the next start bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

    logic            rx_s;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            rdy_q, rdy_d;
    logic            hold_q, hold_d;
    logic            frm_q, frm_d;
    logic            armed_q, armed_d;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (RX),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            hold_q  <= 1'b0;
            frm_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            hold_q  <= hold_d;
            frm_q   <= frm_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        hold_d  = hold_q & ~clr_rdy;
        frm_d   = 1'b0;
        armed_d = armed_q;

        if (clr_rdy) begin
            rdy_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // armed_q stays low after a framing error until the line is seen high again
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = RECEIVE;
                    baud_d  = HALF_BIT;
                    bit_d   = '0;
                    rdy_d   = 1'b0;
                    hold_d  = rdy_q & ~clr_rdy;
                end
            end
            RECEIVE: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CW'(1);
                end else begin
                    baud_d = FULL_BIT;
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == START_IDX) begin
                        // High at the start-bit midpoint is a glitch: restore the pre-frame rdy
                        if (rx_s) begin
                            state_d = IDLE;
                            bit_d   = '0;
                            baud_d  = '0;
                            rdy_d   = hold_q & ~clr_rdy;
                        end
                    end else if (bit_q == STOP_IDX) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        baud_d  = '0;
                        if (rx_s) begin
                            data_d = shift_q;
                            rdy_d  = 1'b1;
                        end else begin
                            frm_d   = 1'b1;
                            armed_d = 1'b0;
                        end
                    end else begin
                        shift_d = {rx_s, shift_q[7:1]};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data = data_q;
    assign rdy     = rdy_q;
    assign frm_err = frm_q;

endmodule
